// File: rtl/spm_sequencer_if.sv
// Operand/product handshake bundle between a bus-side requester and spm_sequencer.
// The master drives operands and accepts products; the slave is the sequencer.
interface spm_sequencer_if #(parameter int BITS = 32);
    logic                  in_valid;
    logic                  in_ready;
    logic [BITS-1:0]       in_a;
    logic [BITS-1:0]       in_x;
    logic                  out_valid;
    logic                  out_ready;
    logic [2*BITS-1:0]     out_p;

    modport master (
        output in_valid, in_a, in_x, out_ready,
        input  in_ready, out_valid, out_p
    );

    modport slave (
        input  in_valid, in_a, in_x, out_ready,
        output in_ready, out_valid, out_p
    );
endinterface

// File: rtl/spm_sequencer.sv
// Sequencer for a bit-serial/parallel multiplier: clears the spm, streams x LSB-first
// with zero padding, and deserialises the 2*BITS-bit product onto a valid/ready port.
module spm_sequencer #(
    parameter int BITS = 32
) (
    input  logic             clk,
    input  logic             rst,
    spm_sequencer_if.slave   bus,
    output logic             busy,
    output logic             spm_clr_n,
    output logic [BITS-1:0]  spm_a,
    output logic             spm_x,
    input  logic             spm_y
);
    localparam int PW = 2 * BITS;
    localparam int CW = $clog2(PW + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(PW);
    localparam logic [CW-1:0] CNT_XEND = CW'(BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [BITS-1:0] a_reg, a_next;
    logic [BITS-1:0] x_reg, x_next;
    logic [PW-1:0]   p_reg, p_next;
    logic [PW-1:0]   p_shift;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            clr_n_reg;

    // Product deserialiser: each serial bit enters at the MSB and walks toward bit 0.
    genvar gi;
    assign p_shift[PW-1] = spm_y;
    generate
        for (gi = 0; gi < PW - 1; gi++) begin : g_pshift
            assign p_shift[gi] = p_reg[gi+1];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        x_next     = x_reg;
        p_next     = p_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    a_next     = bus.in_a;
                    x_next     = bus.in_x;
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                cnt_next   = '0;
                state_next = RUN;
            end
            RUN: begin
                x_next   = x_reg >> 1;
                cnt_next = cnt_reg + CW'(1);
                // spm output is one cycle late, so cnt=0 carries no product bit yet.
                if (cnt_reg != '0)
                    p_next = p_shift;
                if (cnt_reg == CNT_LAST)
                    state_next = DONE;
            end
            DONE: begin
                if (bus.out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            x_reg     <= '0;
            p_reg     <= '0;
            cnt_reg   <= '0;
            clr_n_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            x_reg     <= x_next;
            p_reg     <= p_next;
            cnt_reg   <= cnt_next;
            // Registered so the spm reset line never glitches on state decode.
            clr_n_reg <= (state_next != CLEAR);
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.out_p     = p_reg;
    assign busy          = (state_reg != IDLE);
    assign spm_clr_n     = clr_n_reg;
    assign spm_a         = a_reg;
    assign spm_x         = ((state_reg == RUN) && (cnt_reg < CNT_XEND)) ? x_reg[0] : 1'b0;
endmodule

// File: tb/tb_spm_sequencer.sv
// Randomised scoreboard bench for spm_sequencer with a behavioural serial/parallel
// multiplier attached; expected products are plain a*x.
module tb_spm_sequencer;
    localparam int BITS = 8;
    localparam int LAT  = 2 * BITS + 2;

    logic clk;
    logic rst;
    logic busy;
    logic spm_clr_n;
    logic [BITS-1:0] spm_a;
    logic spm_x;
    logic spm_y;

    spm_sequencer_if #(.BITS(BITS)) bus();

    spm_sequencer #(.BITS(BITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .spm_clr_n (spm_clr_n),
        .spm_a     (spm_a),
        .spm_x     (spm_x),
        .spm_y     (spm_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural spm: accumulate a when the x bit is 1, emit the LSB, keep the rest.
    logic [BITS-1:0] spm_acc;
    logic [BITS:0]   spm_sum;
    assign spm_sum = {1'b0, spm_acc} + (spm_x ? {1'b0, spm_a} : '0);
    always @(posedge clk or negedge spm_clr_n) begin
        if (!spm_clr_n) begin
            spm_acc <= '0;
            spm_y   <= 1'b0;
        end else begin
            spm_y   <= spm_sum[0];
            spm_acc <= spm_sum[BITS:1];
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [2*BITS-1:0] exp_q[$];
    int lat_q[$];
    logic prev_valid = 1'b0;
    logic rand_ready = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: latency on each rising out_valid, product on each handshake.
    always @(negedge clk) begin
        if (rst) begin
            chk("ready_vs_busy", {63'd0, bus.in_ready}, {63'd0, ~busy});
            if (bus.out_valid && !prev_valid) begin
                if (lat_q.size() == 0) chk("latency_unexpected", 64'd1, 64'd0);
                else chk("latency", 64'(cyc - lat_q.pop_front()), 64'(LAT));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) chk("product_unexpected", {48'd0, bus.out_p}, 64'd0);
                else begin
                    logic [2*BITS-1:0] e;
                    e = exp_q.pop_front();
                    chk("product", {48'd0, bus.out_p}, {48'd0, e});
                    $display("op done p=%04h exp=%04h t=%0t", bus.out_p, e, $time);
                end
            end
            prev_valid = bus.out_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    // Presents a pair and waits for acceptance; returns at accept edge + 1.
    task automatic send(input logic [BITS-1:0] a, input logic [BITS-1:0] x);
        int n;
        bool_ok: begin end
        bus.in_a = a;
        bus.in_x = x;
        bus.in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 300) break;
        end
        if (n > 300) begin
            chk("timeout_accept", 64'd1, 64'd0);
        end else begin
            exp_q.push_back({{BITS{1'b0}}, a} * {{BITS{1'b0}}, x});
            lat_q.push_back(cyc + 1);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_a = BITS'($urandom);
        bus.in_x = BITS'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  {63'd0, bus.in_ready},  64'd1);
        chk({tag, "_out_valid"}, {63'd0, bus.out_valid}, 64'd0);
        chk({tag, "_busy"},      {63'd0, busy},          64'd0);
        chk({tag, "_out_p"},     {48'd0, bus.out_p},     64'd0);
        chk({tag, "_spm_clr_n"}, {63'd0, spm_clr_n},     64'd0);
    endtask

    initial begin
        logic [BITS-1:0] ra, rx;
        logic [2*BITS-1:0] stall_exp;
        int n;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_x = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        chk("reset_spm_a", {56'd0, spm_a}, 64'd0);
        chk("reset_spm_x", {63'd0, spm_x}, 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        send(8'h03, 8'h05);
        send(8'hFF, 8'hFF);
        send(8'h00, 8'hA5);
        send(8'h5A, 8'h00);
        drain();

        // Consumer stalls 10 cycles with the product presented.
        bus.out_ready = 1'b0;
        send(8'h11, 8'hEF);
        stall_exp = 16'h0FDF;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 100);
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", {63'd0, bus.out_valid}, 64'd1);
            chk("stall_p", {48'd0, bus.out_p}, {48'd0, stall_exp});
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        drain();

        // Second pair is held during the first operation and must wait for DONE.
        send(8'hFF, 8'hFF);
        send(BITS'($urandom), BITS'($urandom));
        drain();

        // Abort at cnt=5 of RUN.
        send(8'h33, 8'h44);
        repeat (6) @(posedge clk);
        #1;
        chk("abort_busy_before", {63'd0, busy}, 64'd1);
        #1;
        rst = 1'b0;
        #1;
        chk_reset_outputs("abort");
        exp_q.delete();
        lat_q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        send(8'h07, 8'h09);
        drain();

        rand_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            ra = BITS'($urandom);
            rx = BITS'($urandom);
            if (k % 10 == 0) ra = '1;
            if (k % 10 == 5) rx = '1;
            send(ra, rx);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        drain();
        rand_ready = 1'b0;
        bus.out_ready = 1'b1;

        chk("final_lat_q_empty", 64'(lat_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
